// File: rtl/bsg_cache_dma_to_simple_mem.sv
// Purpose: turns one cache DMA packet (fill or evict) into single-beat requests on a valid/yumi memory port.
// Latency: first memory request the cycle after packet accept; fill data and evict data pass through with zero added latency.
// Backpressure: fill beats stall on dma_data_ready_i, evict beats on mem_yumi_i; masked-off evict beats drain without a memory request.
module bsg_cache_dma_to_simple_mem #(
    // Defaults only keep stand-alone elaboration legal; integrators always set the first three.
    parameter int addr_width_p          = 32,
    parameter int data_width_p          = 32,
    parameter int block_size_in_words_p = 8,
    parameter int dma_data_width_p      = data_width_p
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,

    input  logic [1+addr_width_p+block_size_in_words_p-1:0] dma_pkt_i,
    input  logic                                          dma_pkt_v_i,
    output logic                                          dma_pkt_yumi_o,

    output logic [dma_data_width_p-1:0]                   dma_data_o,
    output logic                                          dma_data_v_o,
    input  logic                                          dma_data_ready_i,

    input  logic [dma_data_width_p-1:0]                   dma_data_i,
    input  logic                                          dma_data_v_i,
    output logic                                          dma_data_yumi_o,

    output logic                                          mem_v_o,
    output logic                                          mem_w_o,
    output logic [addr_width_p-1:0]                       mem_addr_o,
    output logic [dma_data_width_p-1:0]                   mem_data_o,
    output logic [dma_data_width_p/8-1:0]                 mem_mask_o,
    input  logic                                          mem_yumi_i,

    input  logic [dma_data_width_p-1:0]                   mem_data_i,
    input  logic                                          mem_data_v_i,
    output logic                                          mem_data_ready_o
);

    localparam int word_bytes_lp     = data_width_p / 8;
    localparam int beat_bytes_lp     = dma_data_width_p / 8;
    localparam int words_per_beat_lp = dma_data_width_p / data_width_p;
    localparam int burst_len_lp      = block_size_in_words_p * data_width_p / dma_data_width_p;
    localparam int cnt_width_lp      = $clog2(burst_len_lp + 1);

    localparam logic [cnt_width_lp-1:0] burst_cnt_lp = cnt_width_lp'(burst_len_lp);
    localparam logic [cnt_width_lp-1:0] last_cnt_lp  = cnt_width_lp'(burst_len_lp - 1);
    localparam logic [cnt_width_lp-1:0] one_cnt_lp   = cnt_width_lp'(1);

    typedef struct packed {
        logic                             write_not_read;
        logic [addr_width_p-1:0]          addr;
        logic [block_size_in_words_p-1:0] mask;
    } dma_pkt_s;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

    dma_pkt_s pkt_in;
    assign pkt_in = dma_pkt_i;

    // The direction bit is consumed by the state choice, so only addr and mask are kept.
    state_e                           state_q,    state_d;
    logic [addr_width_p-1:0]          addr_q,     addr_d;
    logic [block_size_in_words_p-1:0] mask_q,     mask_d;
    logic [cnt_width_lp-1:0]          req_cnt_q,  req_cnt_d;
    logic [cnt_width_lp-1:0]          beat_cnt_q, beat_cnt_d;

    logic [words_per_beat_lp-1:0]     beat_mask;
    logic [dma_data_width_p/8-1:0]    byte_mask;
    logic [cnt_width_lp-1:0]          addr_cnt;

    // Pick the word-mask slice for the current evict beat and widen it to a byte mask.
    always_comb begin
        beat_mask = '0;
        byte_mask = '0;
        for (int w = 0; w < words_per_beat_lp; w++) begin
            beat_mask[w] = mask_q[int'(beat_cnt_q) * words_per_beat_lp + w];
            byte_mask[w*word_bytes_lp +: word_bytes_lp] = {word_bytes_lp{beat_mask[w]}};
        end
    end

    // Reads advance by request count, writes by beat count; the sum wraps at the address width.
    assign addr_cnt   = (state_q == WRITE) ? beat_cnt_q : req_cnt_q;
    assign mem_addr_o = addr_q + addr_width_p'(32'(addr_cnt) * beat_bytes_lp);
    assign mem_data_o = dma_data_i;
    assign dma_data_o = mem_data_i;

    // Handshake outputs decode from state; all are held low while reset is asserted.
    always_comb begin
        dma_pkt_yumi_o   = 1'b0;
        dma_data_v_o     = 1'b0;
        dma_data_yumi_o  = 1'b0;
        mem_v_o          = 1'b0;
        mem_w_o          = 1'b0;
        mem_mask_o       = '0;
        mem_data_ready_o = 1'b0;
        if (!reset_i) begin
            case (state_q)
                IDLE: dma_pkt_yumi_o = dma_pkt_v_i;
                READ: begin
                    mem_v_o          = (req_cnt_q < burst_cnt_lp);
                    dma_data_v_o     = mem_data_v_i;
                    mem_data_ready_o = dma_data_ready_i;
                end
                WRITE: begin
                    mem_w_o    = 1'b1;
                    mem_mask_o = byte_mask;
                    if (|beat_mask) begin
                        mem_v_o         = dma_data_v_i;
                        dma_data_yumi_o = mem_yumi_i;
                    end else begin
                        // Fully masked beat: drain it from the cache without touching memory.
                        dma_data_yumi_o = dma_data_v_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state: latch the packet in IDLE, count requests and beats, leave on the last beat.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        mask_d     = mask_q;
        req_cnt_d  = req_cnt_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (dma_pkt_v_i) begin
                    addr_d     = pkt_in.addr;
                    mask_d     = pkt_in.mask;
                    req_cnt_d  = '0;
                    beat_cnt_d = '0;
                    state_d    = pkt_in.write_not_read ? WRITE : READ;
                end
            end
            READ: begin
                if (mem_v_o && mem_yumi_i) begin
                    req_cnt_d = req_cnt_q + one_cnt_lp;
                end
                if (mem_data_v_i && dma_data_ready_i) begin
                    beat_cnt_d = beat_cnt_q + one_cnt_lp;
                    if (beat_cnt_q == last_cnt_lp) begin
                        state_d = IDLE;
                    end
                end
            end
            WRITE: begin
                if (dma_data_yumi_o) begin
                    beat_cnt_d = beat_cnt_q + one_cnt_lp;
                    if (beat_cnt_q == last_cnt_lp) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset back to IDLE and cleared counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            mask_q     <= '0;
            req_cnt_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mask_q     <= mask_d;
            req_cnt_q  <= req_cnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Memory must never present more read responses than requests it has accepted.
    assert property (@(posedge clk_i) disable iff (reset_i)
        (state_q == READ && mem_data_v_i) |-> (beat_cnt_q < req_cnt_q));

endmodule

// File: tb/tb_bsg_cache_dma_to_simple_mem.sv
// Bench for bsg_cache_dma_to_simple_mem: 32-bit words, 64-bit beats, 8-word blocks (4 beats per block).
// Directed fill/evict/stall/reset scenarios followed by randomized packets against a transaction-level model.
// The bench also plays the memory: it queues accepted read addresses and answers them in order.
module tb_bsg_cache_dma_to_simple_mem;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BW    = 8;
    localparam int DDW   = 64;
    localparam int BURST = 4;
    localparam int PKTW  = 1 + AW + BW;

    logic             clk = 1'b0;
    logic             reset_i;
    logic [PKTW-1:0]  dma_pkt_i;
    logic             dma_pkt_v_i;
    logic             dma_pkt_yumi_o;
    logic [DDW-1:0]   dma_data_o;
    logic             dma_data_v_o;
    logic             dma_data_ready_i;
    logic [DDW-1:0]   dma_data_i;
    logic             dma_data_v_i;
    logic             dma_data_yumi_o;
    logic             mem_v_o;
    logic             mem_w_o;
    logic [AW-1:0]    mem_addr_o;
    logic [DDW-1:0]   mem_data_o;
    logic [DDW/8-1:0] mem_mask_o;
    logic             mem_yumi_i;
    logic [DDW-1:0]   mem_data_i;
    logic             mem_data_v_i;
    logic             mem_data_ready_o;

    always #5 clk = ~clk;

    bsg_cache_dma_to_simple_mem #(
        .addr_width_p          (AW),
        .data_width_p          (DW),
        .block_size_in_words_p (BW),
        .dma_data_width_p      (DDW)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .dma_pkt_i        (dma_pkt_i),
        .dma_pkt_v_i      (dma_pkt_v_i),
        .dma_pkt_yumi_o   (dma_pkt_yumi_o),
        .dma_data_o       (dma_data_o),
        .dma_data_v_o     (dma_data_v_o),
        .dma_data_ready_i (dma_data_ready_i),
        .dma_data_i       (dma_data_i),
        .dma_data_v_i     (dma_data_v_i),
        .dma_data_yumi_o  (dma_data_yumi_o),
        .mem_v_o          (mem_v_o),
        .mem_w_o          (mem_w_o),
        .mem_addr_o       (mem_addr_o),
        .mem_data_o       (mem_data_o),
        .mem_mask_o       (mem_mask_o),
        .mem_yumi_i       (mem_yumi_i),
        .mem_data_i       (mem_data_i),
        .mem_data_v_i     (mem_data_v_i),
        .mem_data_ready_o (mem_data_ready_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Addresses of reads the memory has accepted but not yet answered, oldest first.
    logic [31:0] pend[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a * 32'h9E37_79B1, a ^ 32'hC001_D00D};
    endfunction

    function automatic logic [7:0] expand(input logic [1:0] bm);
        return {{4{bm[1]}}, {4{bm[0]}}};
    endfunction

    function automatic bit rnd(input int pct);
        return int'($urandom_range(99, 0)) < pct;
    endfunction

    // Drives one packet through to completion and checks every cycle against the model.
    task automatic run_pkt(input bit w, input logic [31:0] addr, input logic [7:0] mask,
                           input int yumi_pct, input int rv_pct, input int rdy_pct,
                           input int ev_pct, input int pv_busy_pct,
                           input int stall_from, input int stall_len, input int reset_at,
                           output int n_mem);
        bit          busy, accepted, done;
        int          beat, reqs, cyc;
        logic [63:0] ev[4];
        logic [1:0]  bm;
        bit          e_pyumi, e_mv, e_dv, e_mrdy, e_dyumi;
        busy = 0; accepted = 0; done = 0;
        beat = 0; reqs = 0; cyc = 0; n_mem = 0;
        foreach (ev[i]) ev[i] = {$urandom, $urandom};
        while (!done) begin
            @(negedge clk);
            cyc++;
            if (cyc > 400) begin
                chk("pkt_cycle_budget", 64'(cyc), 64'd400);
                break;
            end
            reset_i = 1'b0;
            if (reset_at >= 0 && busy && beat == reset_at) begin
                reset_i          = 1'b1;
                dma_pkt_v_i      = 1'b1;
                dma_data_v_i     = 1'b1;
                dma_data_ready_i = 1'b1;
                mem_data_v_i     = 1'b0;
                mem_yumi_i       = 1'b0;
                #2;
                chk("rst_mem_v",     mem_v_o, 0);
                chk("rst_dma_yumi",  dma_data_yumi_o, 0);
                chk("rst_pkt_yumi",  dma_pkt_yumi_o, 0);
                chk("rst_dma_v",     dma_data_v_o, 0);
                chk("rst_mem_ready", mem_data_ready_o, 0);
                pend.delete();
                done = 1;
            end else begin
                dma_pkt_i        = {w, addr, mask};
                dma_pkt_v_i      = accepted ? rnd(pv_busy_pct) : 1'b1;
                dma_data_ready_i = (cyc >= stall_from && cyc < stall_from + stall_len) ? 1'b0 : rnd(rdy_pct);
                mem_data_v_i     = (pend.size() > 0) && rnd(rv_pct);
                mem_data_i       = mem_data_v_i ? mem_word(pend[0]) : {$urandom, $urandom};
                dma_data_v_i     = busy && w && rnd(ev_pct);
                dma_data_i       = (busy && w && beat < BURST) ? ev[beat] : {$urandom, $urandom};
                mem_yumi_i       = 1'b0;
                #1;
                mem_yumi_i       = mem_v_o && rnd(yumi_pct);
                #1;
                bm      = (busy && w) ? mask[beat*2 +: 2] : 2'b00;
                e_pyumi = !busy && dma_pkt_v_i;
                e_mv    = busy && (w ? (bm != 2'b00 && dma_data_v_i) : (reqs < BURST));
                e_dv    = busy && !w && mem_data_v_i;
                e_mrdy  = busy && !w && dma_data_ready_i;
                e_dyumi = busy && w && ((bm != 2'b00) ? mem_yumi_i : dma_data_v_i);
                chk("pkt_yumi",   dma_pkt_yumi_o,   e_pyumi);
                chk("mem_v",      mem_v_o,          e_mv);
                chk("fill_v",     dma_data_v_o,     e_dv);
                chk("mem_ready",  mem_data_ready_o, e_mrdy);
                chk("evict_yumi", dma_data_yumi_o,  e_dyumi);
                if (e_dv && dma_data_ready_i)
                    chk("fill_data", dma_data_o, mem_word(addr + 32'(8 * beat)));
                if (mem_v_o && mem_yumi_i) begin
                    n_mem++;
                    if (w) begin
                        chk("wr_addr", mem_addr_o, addr + 32'(8 * beat));
                        chk("wr_w",    mem_w_o,    1);
                        chk("wr_mask", mem_mask_o, expand(bm));
                        chk("wr_data", mem_data_o, (beat < BURST) ? ev[beat] : 64'd0);
                    end else begin
                        chk("rd_addr", mem_addr_o, addr + 32'(8 * reqs));
                        chk("rd_w",    mem_w_o,    0);
                        chk("rd_mask", mem_mask_o, 0);
                    end
                    if (!mem_w_o) pend.push_back(mem_addr_o);
                end
                if (mem_data_v_i && mem_data_ready_o) void'(pend.pop_front());
                if (!busy) begin
                    if (dma_pkt_v_i) begin
                        busy = 1; accepted = 1; beat = 0; reqs = 0;
                    end
                end else if (w) begin
                    if (e_dyumi) begin
                        beat++;
                        if (beat == BURST) begin busy = 0; done = 1; end
                    end
                end else begin
                    if (e_mv && mem_yumi_i) reqs++;
                    if (mem_data_v_i && dma_data_ready_i) begin
                        beat++;
                        if (beat == BURST) begin busy = 0; done = 1; end
                    end
                end
            end
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic [7:0]  m;
        logic [31:0] a;
        reset_i          = 1'b1;
        dma_pkt_i        = '0;
        dma_pkt_v_i      = 1'b0;
        dma_data_ready_i = 1'b1;
        dma_data_i       = '0;
        dma_data_v_i     = 1'b0;
        mem_yumi_i       = 1'b0;
        mem_data_i       = '0;
        mem_data_v_i     = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_mem_v",     mem_v_o, 0);
        chk("reset_fill_v",    dma_data_v_o, 0);
        chk("reset_evict_yumi", dma_data_yumi_o, 0);
        chk("reset_pkt_yumi",  dma_pkt_yumi_o, 0);
        chk("reset_mem_ready", mem_data_ready_o, 0);
        reset_i = 1'b0;
        #1;
        chk("idle_mem_v",     mem_v_o, 0);
        chk("idle_mem_ready", mem_data_ready_o, 0);

        // Fill at 0x1000 with an eager memory and a second packet held valid throughout.
        run_pkt(0, 32'h1000, 8'h00, 100, 100, 100, 100, 100, -1, 0, -1, n);
        chk("t1_read_count", 64'(n), 4);
        // Fill with the cache fill fifo blocked for three cycles mid-burst.
        run_pkt(0, 32'h1100, 8'h00, 100, 100, 100, 100, 0, 3, 3, -1, n);
        chk("t2_read_count", 64'(n), 4);
        // Full evict.
        run_pkt(1, 32'h2000, 8'hFF, 100, 100, 100, 100, 0, -1, 0, -1, n);
        chk("t3_write_count", 64'(n), 4);
        // Evict where only word 4 is dirty: one write of the low half of beat 2.
        run_pkt(1, 32'h2000, 8'h10, 100, 100, 100, 100, 0, -1, 0, -1, n);
        chk("t4_write_count", 64'(n), 1);
        // Reset after two evict beats, then a fresh fill must be taken immediately.
        run_pkt(1, 32'h2040, 8'hFF, 100, 100, 100, 100, 0, -1, 0, 2, n);
        chk("t5_writes_before_reset", 64'(n), 2);
        @(negedge clk);
        reset_i      = 1'b0;
        dma_pkt_v_i  = 1'b0;
        dma_data_v_i = 1'b1;
        mem_data_v_i = 1'b0;
        mem_yumi_i   = 1'b0;
        #2;
        chk("post_rst_mem_v",      mem_v_o, 0);
        chk("post_rst_evict_yumi", dma_data_yumi_o, 0);
        chk("post_rst_pkt_yumi",   dma_pkt_yumi_o, 0);
        run_pkt(0, 32'h3000, 8'h00, 100, 100, 100, 100, 0, -1, 0, -1, n);
        chk("t5_fill_count", 64'(n), 4);

        // Randomized packets with random memory, response and cache-side stalls.
        for (int i = 0; i < 1000; i++) begin
            a = $urandom & 32'hFFFF_FFE0;
            case ($urandom_range(3, 0))
                0:       m = 8'hFF;
                1:       m = 8'h00;
                default: m = 8'($urandom);
            endcase
            run_pkt(1'($urandom_range(1, 0)), a, m,
                    int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                    int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                    50, -1, 0, -1, n);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
